// File: rtl/slice_position_generator.sv
// Splits each measured rotation into 2^SLICES_LOG2 equal slices and drives the
// slice strobe, slice index and one-hot column select for the LED controller.
module slice_position_generator #(
  parameter int SLICES_LOG2   = 7,
  parameter int PERIOD_W      = 24,
  parameter int MUX_W         = 8,
  parameter int MUX_OFFSET    = 7,
  parameter int MIN_SLICE_LEN = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   hall_tick,
  output logic                   position_sync,
  output logic [SLICES_LOG2-1:0] slice_cnt,
  output logic [MUX_W-1:0]       fpga_mul,
  output logic [PERIOD_W-1:0]    period,
  output logic                   running,
  output logic                   stalled
);

  localparam int TIMER_W = PERIOD_W - SLICES_LOG2;
  localparam logic [SLICES_LOG2-1:0] LAST_SLICE = '1;
  localparam logic [PERIOD_W-1:0]    REV_MAX    = '1;
  localparam logic [TIMER_W-1:0]     MIN_LEN    = TIMER_W'(MIN_SLICE_LEN);

  typedef enum logic [1:0] {IDLE, ARMED, RUN, STALL} state_t;

  state_t                  state, state_next;
  logic [PERIOD_W-1:0]     rev_cnt;
  logic [PERIOD_W-1:0]     meas_period;
  logic [TIMER_W-1:0]      meas_slice_len;
  logic [TIMER_W-1:0]      slice_len;
  logic [TIMER_W-1:0]      timer, timer_next;
  logic [PERIOD_W-1:0]     period_next;
  logic [SLICES_LOG2-1:0]  slice_next;
  logic [MUX_W-1:0]        mul_next;
  logic                    sync_next;
  logic                    rev_sat;
  logic                    meas_valid;
  logic                    accept;

  assign rev_sat        = (rev_cnt == REV_MAX);
  assign meas_period    = rev_cnt + PERIOD_W'(1);
  assign meas_slice_len = TIMER_W'(meas_period >> SLICES_LOG2);
  assign meas_valid     = !rev_sat && (meas_slice_len >= MIN_LEN);
  assign slice_len      = TIMER_W'(period >> SLICES_LOG2);
  // A tick only (re)starts the slice sequence when a turn is already being timed
  assign accept         = hall_tick && meas_valid && (state == ARMED || state == RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      rev_cnt <= '0;
    end else if (hall_tick) begin
      rev_cnt <= '0;
    end else if (!rev_sat) begin
      rev_cnt <= rev_cnt + PERIOD_W'(1);
    end
  end

  always_comb begin
    state_next  = state;
    timer_next  = timer;
    slice_next  = slice_cnt;
    period_next = period;
    sync_next   = 1'b0;
    if (accept) begin
      state_next  = RUN;
      period_next = meas_period;
      slice_next  = '0;
      timer_next  = '0;
      sync_next   = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (hall_tick) state_next = ARMED;
        end
        ARMED: begin
          if (!hall_tick && rev_sat) state_next = IDLE;
        end
        RUN: begin
          if (hall_tick) begin
            state_next = ARMED;
          end else if (rev_sat) begin
            state_next = STALL;
          end else if (timer == slice_len - TIMER_W'(1)) begin
            // The last slice is held with the timer parked until the next tick
            if (slice_cnt != LAST_SLICE) begin
              slice_next = slice_cnt + SLICES_LOG2'(1);
              timer_next = '0;
              sync_next  = 1'b1;
            end
          end else begin
            timer_next = timer + TIMER_W'(1);
          end
        end
        STALL: begin
          if (hall_tick) state_next = ARMED;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    mul_next = '0;
    if (state_next == RUN) begin
      mul_next = MUX_W'(1) << ((int'(slice_next) + MUX_OFFSET) % MUX_W);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      timer         <= '0;
      slice_cnt     <= '0;
      period        <= '0;
      position_sync <= 1'b0;
      fpga_mul      <= '0;
      running       <= 1'b0;
      stalled       <= 1'b0;
    end else begin
      state         <= state_next;
      timer         <= timer_next;
      slice_cnt     <= slice_next;
      period        <= period_next;
      position_sync <= sync_next;
      fpga_mul      <= mul_next;
      running       <= (state_next == RUN);
      stalled       <= (state_next == STALL);
    end
  end

endmodule

// File: tb/tb_slice_position_generator.sv
// Directed bench for slice_position_generator; PERIOD_W=12 so rotation stalls
// can be reached quickly.
module tb_slice_position_generator;

  localparam int SL = 7;
  localparam int PW = 12;
  localparam int MW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          hall_tick;
  logic          position_sync;
  logic [SL-1:0] slice_cnt;
  logic [MW-1:0] fpga_mul;
  logic [PW-1:0] period;
  logic          running;
  logic          stalled;

  int tests_run = 0;
  int tests_failed = 0;
  int sync_total = 0;
  int snap;

  slice_position_generator #(
    .SLICES_LOG2(SL), .PERIOD_W(PW), .MUX_W(MW), .MUX_OFFSET(7), .MIN_SLICE_LEN(2)
  ) dut (
    .clk(clk), .rst(rst), .hall_tick(hall_tick), .position_sync(position_sync),
    .slice_cnt(slice_cnt), .fpga_mul(fpga_mul), .period(period),
    .running(running), .stalled(stalled)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (position_sync) sync_total <= sync_total + 1;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Tick is sampled on the next edge; returns 1 time unit after that edge
  task automatic do_tick();
    hall_tick = 1'b1;
    @(posedge clk);
    #1;
    hall_tick = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    hall_tick = 1'b0;
    step(3);
    tests_run++; if (position_sync !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_sync got=%0h exp=0", position_sync); end
    tests_run++; if (slice_cnt !== 7'd0) begin tests_failed++; $display("[TB] FAIL reset_slice got=%0d exp=0", slice_cnt); end
    tests_run++; if (fpga_mul !== 8'h00) begin tests_failed++; $display("[TB] FAIL reset_mul got=%0h exp=00", fpga_mul); end
    tests_run++; if (period !== 12'd0) begin tests_failed++; $display("[TB] FAIL reset_period got=%0d exp=0", period); end
    tests_run++; if (running !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_running got=%0h exp=0", running); end
    tests_run++; if (stalled !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_stalled got=%0h exp=0", stalled); end
    rst = 1'b0;
  endtask

  task automatic test_startup();
    // First tick arms only, even though a valid-looking interval has elapsed
    step(1299);
    do_tick();
    tests_run++; if (running !== 1'b0) begin tests_failed++; $display("[TB] FAIL arm_running got=%0h exp=0", running); end
    tests_run++; if (position_sync !== 1'b0) begin tests_failed++; $display("[TB] FAIL arm_sync got=%0h exp=0", position_sync); end
    snap = sync_total;
    step(1279);
    do_tick();
    tests_run++; if (sync_total - snap !== 0) begin tests_failed++; $display("[TB] FAIL early_pulses got=%0d exp=0", sync_total - snap); end
    tests_run++; if (running !== 1'b1) begin tests_failed++; $display("[TB] FAIL start_running got=%0h exp=1", running); end
    tests_run++; if (period !== 12'd1280) begin tests_failed++; $display("[TB] FAIL start_period got=%0d exp=1280", period); end
    tests_run++; if (slice_cnt !== 7'd0) begin tests_failed++; $display("[TB] FAIL start_slice got=%0d exp=0", slice_cnt); end
    tests_run++; if (fpga_mul !== 8'h80) begin tests_failed++; $display("[TB] FAIL start_mul got=%0h exp=80", fpga_mul); end
    tests_run++; if (position_sync !== 1'b1) begin tests_failed++; $display("[TB] FAIL start_sync got=%0h exp=1", position_sync); end
    snap = sync_total;
    step(1);
    tests_run++; if (position_sync !== 1'b0) begin tests_failed++; $display("[TB] FAIL sync_width got=%0h exp=0", position_sync); end
    step(9);
    tests_run++; if (position_sync !== 1'b1) begin tests_failed++; $display("[TB] FAIL s1_sync got=%0h exp=1", position_sync); end
    tests_run++; if (slice_cnt !== 7'd1) begin tests_failed++; $display("[TB] FAIL s1_slice got=%0d exp=1", slice_cnt); end
    tests_run++; if (fpga_mul !== 8'h01) begin tests_failed++; $display("[TB] FAIL s1_mul got=%0h exp=01", fpga_mul); end
    step(60);
    tests_run++; if (slice_cnt !== 7'd7) begin tests_failed++; $display("[TB] FAIL s7_slice got=%0d exp=7", slice_cnt); end
    tests_run++; if (fpga_mul !== 8'h40) begin tests_failed++; $display("[TB] FAIL s7_mul got=%0h exp=40", fpga_mul); end
    step(1200);
    tests_run++; if (slice_cnt !== 7'd127) begin tests_failed++; $display("[TB] FAIL s127_slice got=%0d exp=127", slice_cnt); end
    tests_run++; if (position_sync !== 1'b1) begin tests_failed++; $display("[TB] FAIL s127_sync got=%0h exp=1", position_sync); end
    step(9);
    tests_run++; if (slice_cnt !== 7'd127) begin tests_failed++; $display("[TB] FAIL hold_slice got=%0d exp=127", slice_cnt); end
    tests_run++; if (position_sync !== 1'b0) begin tests_failed++; $display("[TB] FAIL hold_sync got=%0h exp=0", position_sync); end
    do_tick();
    tests_run++; if (sync_total - snap !== 128) begin tests_failed++; $display("[TB] FAIL turn1_pulses got=%0d exp=128", sync_total - snap); end
    tests_run++; if (slice_cnt !== 7'd0) begin tests_failed++; $display("[TB] FAIL wrap_slice got=%0d exp=0", slice_cnt); end
    tests_run++; if (position_sync !== 1'b1) begin tests_failed++; $display("[TB] FAIL wrap_sync got=%0h exp=1", position_sync); end
  endtask

  task automatic test_steady();
    snap = sync_total;
    step(645);
    tests_run++; if (slice_cnt !== 7'd64) begin tests_failed++; $display("[TB] FAIL mid_slice got=%0d exp=64", slice_cnt); end
    tests_run++; if (fpga_mul !== 8'h80) begin tests_failed++; $display("[TB] FAIL mid_mul got=%0h exp=80", fpga_mul); end
    step(634);
    tests_run++; if (slice_cnt !== 7'd127) begin tests_failed++; $display("[TB] FAIL steady_end_slice got=%0d exp=127", slice_cnt); end
    do_tick();
    tests_run++; if (sync_total - snap !== 128) begin tests_failed++; $display("[TB] FAIL turn2_pulses got=%0d exp=128", sync_total - snap); end
    tests_run++; if (slice_cnt !== 7'd0) begin tests_failed++; $display("[TB] FAIL turn2_slice got=%0d exp=0", slice_cnt); end
  endtask

  task automatic test_speedup();
    step(999);
    tests_run++; if (slice_cnt !== 7'd99) begin tests_failed++; $display("[TB] FAIL pre_speedup_slice got=%0d exp=99", slice_cnt); end
    snap = sync_total;
    do_tick();
    tests_run++; if (position_sync !== 1'b1) begin tests_failed++; $display("[TB] FAIL speedup_sync got=%0h exp=1", position_sync); end
    tests_run++; if (slice_cnt !== 7'd0) begin tests_failed++; $display("[TB] FAIL speedup_slice got=%0d exp=0", slice_cnt); end
    tests_run++; if (period !== 12'd1000) begin tests_failed++; $display("[TB] FAIL speedup_period got=%0d exp=1000", period); end
    tests_run++; if (sync_total - snap !== 0) begin tests_failed++; $display("[TB] FAIL speedup_extra got=%0d exp=0", sync_total - snap); end
    step(6);
    tests_run++; if (position_sync !== 1'b0 || slice_cnt !== 7'd0) begin tests_failed++; $display("[TB] FAIL len7_early got sync=%0h slice=%0d exp sync=0 slice=0", position_sync, slice_cnt); end
    step(1);
    tests_run++; if (position_sync !== 1'b1 || slice_cnt !== 7'd1) begin tests_failed++; $display("[TB] FAIL len7_step got sync=%0h slice=%0d exp sync=1 slice=1", position_sync, slice_cnt); end
  endtask

  task automatic test_coincide();
    step(692);
    tests_run++; if (slice_cnt !== 7'd99) begin tests_failed++; $display("[TB] FAIL pre_coincide_slice got=%0d exp=99", slice_cnt); end
    snap = sync_total;
    do_tick();
    tests_run++; if (slice_cnt !== 7'd0) begin tests_failed++; $display("[TB] FAIL coincide_slice got=%0d exp=0", slice_cnt); end
    tests_run++; if (period !== 12'd700) begin tests_failed++; $display("[TB] FAIL coincide_period got=%0d exp=700", period); end
    step(1);
    tests_run++; if (sync_total - snap !== 1) begin tests_failed++; $display("[TB] FAIL coincide_pulses got=%0d exp=1", sync_total - snap); end
    tests_run++; if (slice_cnt !== 7'd0 || position_sync !== 1'b0) begin tests_failed++; $display("[TB] FAIL coincide_after got slice=%0d sync=%0h exp slice=0 sync=0", slice_cnt, position_sync); end
  endtask

  task automatic test_too_short();
    step(198);
    do_tick();
    tests_run++; if (running !== 1'b0) begin tests_failed++; $display("[TB] FAIL short_running got=%0h exp=0", running); end
    tests_run++; if (fpga_mul !== 8'h00) begin tests_failed++; $display("[TB] FAIL short_mul got=%0h exp=00", fpga_mul); end
    tests_run++; if (position_sync !== 1'b0) begin tests_failed++; $display("[TB] FAIL short_sync got=%0h exp=0", position_sync); end
    snap = sync_total;
    for (int i = 0; i < 3; i++) begin
      step(199);
      do_tick();
      tests_run++; if (running !== 1'b0) begin tests_failed++; $display("[TB] FAIL armed_repeat%0d got=%0h exp=0", i, running); end
    end
    step(50);
    tests_run++; if (fpga_mul !== 8'h00) begin tests_failed++; $display("[TB] FAIL armed_mul got=%0h exp=00", fpga_mul); end
    tests_run++; if (sync_total - snap !== 0) begin tests_failed++; $display("[TB] FAIL armed_pulses got=%0d exp=0", sync_total - snap); end
    step(1229);
    do_tick();
    tests_run++; if (running !== 1'b1 || position_sync !== 1'b1) begin tests_failed++; $display("[TB] FAIL rearm_run got run=%0h sync=%0h exp 1 1", running, position_sync); end
    tests_run++; if (period !== 12'd1280) begin tests_failed++; $display("[TB] FAIL rearm_period got=%0d exp=1280", period); end
  endtask

  task automatic test_stall();
    step(4000);
    tests_run++; if (running !== 1'b1 || stalled !== 1'b0) begin tests_failed++; $display("[TB] FAIL prestall got run=%0h stall=%0h exp 1 0", running, stalled); end
    tests_run++; if (slice_cnt !== 7'd127) begin tests_failed++; $display("[TB] FAIL prestall_slice got=%0d exp=127", slice_cnt); end
    snap = sync_total;
    step(100);
    tests_run++; if (stalled !== 1'b1) begin tests_failed++; $display("[TB] FAIL stall_flag got=%0h exp=1", stalled); end
    tests_run++; if (running !== 1'b0) begin tests_failed++; $display("[TB] FAIL stall_running got=%0h exp=0", running); end
    tests_run++; if (fpga_mul !== 8'h00) begin tests_failed++; $display("[TB] FAIL stall_mul got=%0h exp=00", fpga_mul); end
    tests_run++; if (slice_cnt !== 7'd127 || period !== 12'd1280) begin tests_failed++; $display("[TB] FAIL stall_hold got slice=%0d period=%0d exp 127 1280", slice_cnt, period); end
    tests_run++; if (sync_total - snap !== 0) begin tests_failed++; $display("[TB] FAIL stall_pulses got=%0d exp=0", sync_total - snap); end
    step(20);
    do_tick();
    tests_run++; if (stalled !== 1'b0 || running !== 1'b0) begin tests_failed++; $display("[TB] FAIL unstall_armed got stall=%0h run=%0h exp 0 0", stalled, running); end
    step(1279);
    do_tick();
    tests_run++; if (running !== 1'b1 || slice_cnt !== 7'd0 || position_sync !== 1'b1) begin tests_failed++; $display("[TB] FAIL unstall_run got run=%0h slice=%0d sync=%0h exp 1 0 1", running, slice_cnt, position_sync); end
  endtask

  task automatic test_reset_mid();
    step(500);
    tests_run++; if (slice_cnt !== 7'd50 || running !== 1'b1) begin tests_failed++; $display("[TB] FAIL premid got slice=%0d run=%0h exp 50 1", slice_cnt, running); end
    rst = 1'b1;
    step(1);
    tests_run++; if (running !== 1'b0 || stalled !== 1'b0 || position_sync !== 1'b0) begin tests_failed++; $display("[TB] FAIL midrst_flags got run=%0h stall=%0h sync=%0h exp 0 0 0", running, stalled, position_sync); end
    tests_run++; if (slice_cnt !== 7'd0 || fpga_mul !== 8'h00 || period !== 12'd0) begin tests_failed++; $display("[TB] FAIL midrst_values got slice=%0d mul=%0h period=%0d exp 0 0 0", slice_cnt, fpga_mul, period); end
    rst = 1'b0;
    step(1299);
    do_tick();
    tests_run++; if (running !== 1'b0) begin tests_failed++; $display("[TB] FAIL post_rst_idle got=%0h exp=0", running); end
  endtask

  initial begin
    test_reset();
    test_startup();
    test_steady();
    test_speedup();
    test_coincide();
    test_too_short();
    test_stall();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
